// File: rtl/serial_subtractor_5.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Produces a - b mod 2^WIDTH and the final borrow.
module serial_subtractor_5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ai, bi, d_bit, br_nxt, last;

  assign ai     = a_q[0];
  assign bi     = b_q[0];
  assign d_bit  = ai ^ bi ^ br_q;
  assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          bo_d    = br_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign diff      = res_q;
  assign borrowOut = bo_q;

endmodule
